// File: rtl/inv_sbox_word.sv
// Four parallel AES inverse S-box lookups on one 32-bit word.
// The table is indexed by the input byte and returns the substituted byte.
module inv_sbox_word (
    input  logic [31:0] word,
    output logic [31:0] sub
);
    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign sub = {INV_SBOX[word[31:24]], INV_SBOX[word[23:16]],
                  INV_SBOX[word[15:8]],  INV_SBOX[word[7:0]]};
endmodule

// File: rtl/decryption_block.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Round keys come from the shared key memory through round/round_key.
module decryption_block (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic [127:0] block,
    input  logic [127:0] round_key,
    output logic [3:0]   round,
    output logic [127:0] new_block,
    output logic         ready
);
    typedef enum logic [1:0] {IDLE, INIT, MAIN, FINAL} state_t;

    state_t       state, state_nxt;
    logic [127:0] data;
    logic [127:0] shifted, subbed, keyed, mixed;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xt(a[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Byte (row r, column c) sits at index 4c+r; row r rotates right by r.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                shifted[127-8*(4*c+r) -: 8] = data[127-8*(4*((c-r+4)%4)+r) -: 8];
    end

    for (genvar w = 0; w < 4; w++) begin : g_sbox
        inv_sbox_word u_sbox (
            .word (shifted[127-32*w -: 32]),
            .sub  (subbed[127-32*w -: 32])
        );
    end

    assign keyed = subbed ^ round_key;

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++)
            mixed[127-32*c -: 32] = inv_mix_col(keyed[127-32*c -: 32]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (next) state_nxt = INIT;
            INIT:    state_nxt = MAIN;
            MAIN:    if (round == 4'd1) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data      <= '0;
            round     <= '0;
            new_block <= '0;
        end else begin
            case (state)
                IDLE: if (next) begin
                    data  <= block;
                    round <= 4'd10;
                end
                INIT: begin
                    data  <= data ^ round_key;
                    round <= 4'd9;
                end
                MAIN: begin
                    data  <= mixed;
                    round <= round - 4'd1;
                end
                FINAL: new_block <= keyed;
                default: ;
            endcase
        end
    end

    assign ready = (state == IDLE);
endmodule

// File: tb/tb_decryption_block.sv
// Directed bench for decryption_block; the bench plays the key memory and
// holds a forward AES model for the round-trip vectors.
module tb_decryption_block;
    logic         clk = 1'b0;
    logic         reset;
    logic         next;
    logic [127:0] block;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic [127:0] new_block;
    logic         ready;

    logic [7:0]   sb [256];
    logic [127:0] rk [16];
    int           n_chk = 0;
    int           n_pass = 0;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    decryption_block dut (
        .clk       (clk),
        .reset     (reset),
        .next      (next),
        .block     (block),
        .round_key (round_key),
        .round     (round),
        .new_block (new_block),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    assign round_key = rk[round];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Forward S-box from its definition: GF inverse (a^254) then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(a));
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [127:0] s;
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   x0, x1, x2, x3;
        s = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) b[4*c+w] = a[4*((c+w)%4)+w];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
                    b[4*c]   = gmul(x0, 8'h02) ^ gmul(x1, 8'h03) ^ x2 ^ x3;
                    b[4*c+1] = x0 ^ gmul(x1, 8'h02) ^ gmul(x2, 8'h03) ^ x3;
                    b[4*c+2] = x0 ^ x1 ^ gmul(x2, 8'h02) ^ gmul(x3, 8'h03);
                    b[4*c+3] = gmul(x0, 8'h03) ^ x1 ^ x2 ^ gmul(x3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = b[i];
            s ^= rk[r];
        end
        return s;
    endfunction

    // One full block from an idle DUT; poke injects ignored next pulses in cycles 3 and 11.
    task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] pt, input bit poke);
        block = ct;
        next  = 1'b1;
        tick();
        for (int k = 1; k <= 11; k++) begin
            check($sformatf("%s round c%0d", tag, k), 128'(round), 128'(11 - k));
            check($sformatf("%s busy c%0d", tag, k), 128'(ready), 128'(0));
            if (poke && (k == 3 || k == 11)) begin
                next  = 1'b1;
                block = '1;
            end else begin
                next = 1'b0;
            end
            tick();
        end
        next = 1'b0;
        check({tag, " ready"}, 128'(ready), 128'(1));
        check({tag, " result"}, new_block, pt);
    endtask

    initial begin
        logic [127:0] pt_rand;
        for (int i = 0; i < 16; i++) rk[i] = '0;
        reset = 1'b1;
        next  = 1'b0;
        block = '0;
        build_sbox();
        #1;
        check("rst ready", 128'(ready), 128'(1));
        check("rst round", 128'(round), 128'(0));
        check("rst new_block", new_block, 128'(0));
        tick();
        reset = 1'b0;
        tick();

        // C.1 with ignored pulses during busy cycles 3 and 11
        load_key(KEY_C1);
        run_block("c1", CT_C1, PT_C1, 1'b1);
        tick();
        check("c1 no restart ready", 128'(ready), 128'(1));
        check("c1 idle round", 128'(round), 128'(0));
        for (int i = 0; i < 20; i++) tick();
        check("c1 hold", new_block, PT_C1);
        check("c1 hold ready", 128'(ready), 128'(1));

        load_key(KEY_B);
        run_block("appb", CT_B, PT_B, 1'b0);
        tick();
        check("appb idle round", 128'(round), 128'(0));

        // back-to-back with next held high
        load_key(KEY_C1);
        block = CT_C1;
        next  = 1'b1;
        tick();
        for (int k = 1; k <= 10; k++) tick();
        check("b2b busy E10", 128'(ready), 128'(0));
        tick();
        check("b2b ready E11", 128'(ready), 128'(1));
        check("b2b result1", new_block, PT_C1);
        load_key(KEY_B);
        block = CT_B;
        tick();
        check("b2b busy E12", 128'(ready), 128'(0));
        check("b2b round E12", 128'(round), 128'(10));
        for (int k = 13; k <= 22; k++) tick();
        check("b2b busy E22", 128'(ready), 128'(0));
        check("b2b hold E22", new_block, PT_C1);
        tick();
        next = 1'b0;
        check("b2b ready E23", 128'(ready), 128'(1));
        check("b2b result2", new_block, PT_B);
        tick();
        check("b2b no restart", 128'(ready), 128'(1));

        // reset in the middle of a run
        load_key(KEY_C1);
        block = CT_C1;
        next  = 1'b1;
        tick();
        next  = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        reset = 1'b1;
        #1;
        check("mid rst ready", 128'(ready), 128'(1));
        check("mid rst new_block", new_block, 128'(0));
        check("mid rst round", 128'(round), 128'(0));
        #1;
        reset = 1'b0;
        tick();
        run_block("post rst", CT_C1, PT_C1, 1'b0);

        // round trips through the forward model
        run_block("rt zero", aes_enc(128'(0)), 128'(0), 1'b0);
        pt_rand = {$urandom, $urandom, $urandom, $urandom};
        run_block("rt rand c1", aes_enc(pt_rand), pt_rand, 1'b0);
        load_key(KEY_B);
        pt_rand = {$urandom, $urandom, $urandom, $urandom};
        run_block("rt rand b", aes_enc(pt_rand), pt_rand, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
